ace_ccu_cm_release_unit: RTL and testbench
==========================================

// Module: ace_ccu_cm_release_unit
// PURPOSE
// - Per-snooped-port generator of conflict-manager release requests (cm_x_req/cm_x_addr).
// - Tracks each snoop from AC issue to completion:
//   - a CR with DataTransfer=0 completes it;
//   - otherwise the CD beat with last=1 completes it.
// - On completion, pulses one release carrying that snoop's line address so the manager frees the entry.
// - Sits inline on the valid/ready wires of one snooped port's AC/CR/CD channels; payloads bypass it.
// PARAMETERS
// - CmAddrWidth    40  width of the line address tracked and released
// - MaxSnoopTrans  4   max snoops outstanding on this port (AC issued, not yet released); >=1
// PORTS
// - clk_i               in   1            clock
// - rst_ni              in   1            asynchronous active-low reset
// - ac_valid_i          in   1            AC request from CCU
// - ac_ready_o          out  1            AC ready to CCU
// - ac_addr_i           in   CmAddrWidth  line address of AC request
// - ac_valid_o          out  1            AC valid to snooped master
// - ac_ready_i          in   1            AC ready from snooped master
// - cr_valid_i          in   1            CR response from snooped master
// - cr_ready_o          out  1            CR ready to snooped master
// - cr_data_transfer_i  in   1            CR.resp[0] (DataTransfer)
// - cr_valid_o          out  1            CR valid to CCU
// - cr_ready_i          in   1            CR ready from CCU
// - cd_valid_i          in   1            CD beat from snooped master
// - cd_ready_o          out  1            CD ready to snooped master
// - cd_last_i           in   1            CD last beat
// - cd_valid_o          out  1            CD valid to CCU
// - cd_ready_i          in   1            CD ready from CCU
// - cm_x_req_o          out  1            release pulse to conflict manager
// - cm_x_addr_o         out  CmAddrWidth  released line address
// - err_o               out  1            sticky protocol error
// BEHAVIOUR
// - Reset:
//   - all queues empty, cnt=0;
//   - cm_x_req_o=0, cm_x_addr_o=0, err_o=0.
//   - Reset mid-operation discards all tracking; no releases are emitted for dropped snoops.
// - Queues:
//   - RQ: FIFO of addresses awaiting CR.
//   - DQ: FIFO of addresses awaiting CD last.
//   - cnt = |RQ| + |DQ|, width $clog2(MaxSnoopTrans+1).
// - AC:
//   - ac_valid_o = ac_valid_i & (cnt<MaxSnoopTrans); ac_ready_o = ac_ready_i & (cnt<MaxSnoopTrans).
//   - A handshake pushes ac_addr_i into RQ.
//   - When full, both AC outputs are 0 and CR/CD keep flowing.
// - CR (in order with AC):
//   - Pass-through valid/ready, gated by blk_cr.
//   - Handshake pops the RQ head.
//   - DataTransfer=1: head moves to DQ tail, no release.
//   - DataTransfer=0: release head.
// - CD (in order):
//   - Pass-through valid/ready, ungated.
//   - Handshake with last=1 pops the DQ head and releases it.
//   - Non-last beats do not change state.
// - Release arbitration, at most one release per cycle:
//   - CD-last has priority.
//   - blk_cr = cd_valid_i & cd_ready_i & cd_last_i & cr_data_transfer_i==0.
//   - When blk_cr is set, cr_valid_o=0 and cr_ready_o=0 that cycle.
// - Release timing:
//   - cm_x_req_o/cm_x_addr_o are registered and asserted exactly 1 cycle after the completing handshake, for 1 cycle.
//   - cm_x_addr_o holds its last value when idle.
// - Simultaneous events: AC push, CR pop/move and CD pop may all occur in one cycle; cnt updates by net change.
// - Empty bypass: a CR arriving with RQ empty is not allowed to bypass; the entry must already exist.
// - Errors (no state change):
//   - CR handshake with RQ empty, or CD-last handshake with DQ empty, sets err_o sticky until reset.
//   - An SVA assertion fires on either.
// TESTING
// 1. AC addr=0x100, then CR DataTransfer=0 -> cm_x_req_o=1, cm_x_addr_o=0x100 exactly one cycle after the CR handshake.
// 2. AC 0x200, CR DT=1, 4 CD beats with last on beat 4 -> no release after CR; release 0x200 one cycle after beat 4 only.
// 3. Four ACs 0xA0..0xD0 with MaxSnoopTrans=4 and a fifth pending -> ac_valid_o=ac_ready_o=0 until the first release; then the fifth issues.
// 4. Same cycle: CD last for 0x300 and CR DT=0 for 0x400 -> CR blocked; release 0x300, then 0x400 on the following cycles.
// 5. CR handshake with no outstanding AC -> err_o=1, cm_x_req_o stays 0; assert rst_ni low mid-burst -> all outputs 0 and queues empty.

Source files
------------

// File: rtl/ace_ccu_cm_release_unit.sv
// ----------------------------------------------------------------------------
// ace_ccu_cm_release_unit
//
// Sits on the valid/ready wires of one snooped port's AC, CR and CD channels
// and produces conflict-manager release requests. Each snoop is tracked from
// its AC handshake to completion:
//   - a CR with DataTransfer=0 completes it immediately;
//   - a CR with DataTransfer=1 hands it over to the data queue, and the CD
//     beat carrying last=1 completes it.
// On completion a single-cycle release (cm_x_req_o/cm_x_addr_o) is issued one
// cycle after the completing handshake. Payloads do not pass through here.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   ac_valid_i/ac_ready_o          AC from CCU (ready gated when tracking full)
//   ac_addr_i                      line address of the AC request
//   ac_valid_o/ac_ready_i          AC to snooped master (valid gated when full)
//   cr_valid_i/cr_ready_o          CR from snooped master
//   cr_data_transfer_i             CR.resp[0]
//   cr_valid_o/cr_ready_i          CR to CCU
//   cd_valid_i/cd_ready_o          CD from snooped master (ungated)
//   cd_last_i                      CD last beat
//   cd_valid_o/cd_ready_i          CD to CCU (ungated)
//   cm_x_req_o/cm_x_addr_o         registered release pulse and its address
//   err_o                          sticky protocol error
//
// Handshake semantics: a transfer happens on a rising clock edge where the
// gated valid and gated ready of a channel are both high. Valid never
// depends on ready of the same direction beyond the gating listed here.
// ----------------------------------------------------------------------------
module ace_ccu_cm_release_unit #(
    parameter int unsigned CmAddrWidth   = 40,
    parameter int unsigned MaxSnoopTrans = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ac_valid_i,
    output logic                   ac_ready_o,
    input  logic [CmAddrWidth-1:0] ac_addr_i,
    output logic                   ac_valid_o,
    input  logic                   ac_ready_i,
    input  logic                   cr_valid_i,
    output logic                   cr_ready_o,
    input  logic                   cr_data_transfer_i,
    output logic                   cr_valid_o,
    input  logic                   cr_ready_i,
    input  logic                   cd_valid_i,
    output logic                   cd_ready_o,
    input  logic                   cd_last_i,
    output logic                   cd_valid_o,
    input  logic                   cd_ready_i,
    output logic                   cm_x_req_o,
    output logic [CmAddrWidth-1:0] cm_x_addr_o,
    output logic                   err_o
);

    localparam int unsigned CntW = $clog2(MaxSnoopTrans + 1);
    localparam int unsigned PtrW = (MaxSnoopTrans > 1) ? $clog2(MaxSnoopTrans) : 1;

    // Wrapping increment that also works for non-power-of-two depths.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxSnoopTrans - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // RQ: snoops awaiting CR. DQ: snoops awaiting the CD last beat.
    logic [CmAddrWidth-1:0] rq_mem_q [MaxSnoopTrans];
    logic [CmAddrWidth-1:0] dq_mem_q [MaxSnoopTrans];
    logic [PtrW-1:0]        rq_wr_ptr_q, rq_wr_ptr_d, rq_rd_ptr_q, rq_rd_ptr_d;
    logic [PtrW-1:0]        dq_wr_ptr_q, dq_wr_ptr_d, dq_rd_ptr_q, dq_rd_ptr_d;
    logic [CntW-1:0]        rq_cnt_q, rq_cnt_d, dq_cnt_q, dq_cnt_d;
    logic [CntW-1:0]        cnt;

    logic                   rel_req_q, rel_req_d;
    logic [CmAddrWidth-1:0] rel_addr_q, rel_addr_d;
    logic                   err_q, err_d;

    logic not_full, rq_nonempty, dq_nonempty;
    logic blk_cr, ac_hs, cr_hs, cd_last_hs;
    logic rq_push, rq_pop, dq_push, dq_pop, cr_release;
    logic [CmAddrWidth-1:0] rq_head, dq_head;

    assign cnt         = rq_cnt_q + dq_cnt_q;
    assign not_full    = (cnt < CntW'(MaxSnoopTrans));
    assign rq_nonempty = (rq_cnt_q != '0);
    assign dq_nonempty = (dq_cnt_q != '0);
    assign rq_head     = rq_mem_q[rq_rd_ptr_q];
    assign dq_head     = dq_mem_q[dq_rd_ptr_q];

    // A CD-last completion owns the single release slot this cycle; a CR that
    // would also release is held off so it completes on a later cycle.
    assign blk_cr = cd_valid_i & cd_ready_i & cd_last_i & ~cr_data_transfer_i;

    assign ac_valid_o = ac_valid_i & not_full;
    assign ac_ready_o = ac_ready_i & not_full;
    assign cr_valid_o = cr_valid_i & ~blk_cr;
    assign cr_ready_o = cr_ready_i & ~blk_cr;
    assign cd_valid_o = cd_valid_i;
    assign cd_ready_o = cd_ready_i;

    assign ac_hs      = ac_valid_i & ac_ready_i & not_full;
    assign cr_hs      = cr_valid_i & cr_ready_i & ~blk_cr;
    assign cd_last_hs = cd_valid_i & cd_ready_i & cd_last_i;

    // Handshakes against an empty queue are flagged and otherwise ignored;
    // the occupancy seen is the one from before this edge, so a same-cycle
    // AC push cannot satisfy a CR.
    assign rq_push    = ac_hs;
    assign rq_pop     = cr_hs & rq_nonempty;
    assign dq_push    = rq_pop & cr_data_transfer_i;
    assign dq_pop     = cd_last_hs & dq_nonempty;
    assign cr_release = rq_pop & ~cr_data_transfer_i;

    always_comb begin
        rq_wr_ptr_d = rq_wr_ptr_q;
        rq_rd_ptr_d = rq_rd_ptr_q;
        dq_wr_ptr_d = dq_wr_ptr_q;
        dq_rd_ptr_d = dq_rd_ptr_q;
        rel_req_d   = 1'b0;
        rel_addr_d  = rel_addr_q;

        if (rq_push) rq_wr_ptr_d = ptr_inc(rq_wr_ptr_q);
        if (rq_pop)  rq_rd_ptr_d = ptr_inc(rq_rd_ptr_q);
        if (dq_push) dq_wr_ptr_d = ptr_inc(dq_wr_ptr_q);
        if (dq_pop)  dq_rd_ptr_d = ptr_inc(dq_rd_ptr_q);

        rq_cnt_d = rq_cnt_q + CntW'(rq_push) - CntW'(rq_pop);
        dq_cnt_d = dq_cnt_q + CntW'(dq_push) - CntW'(dq_pop);

        if (dq_pop) begin
            rel_req_d  = 1'b1;
            rel_addr_d = dq_head;
        end else if (cr_release) begin
            rel_req_d  = 1'b1;
            rel_addr_d = rq_head;
        end

        err_d = err_q | (cr_hs & ~rq_nonempty) | (cd_last_hs & ~dq_nonempty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rq_wr_ptr_q <= '0;
            rq_rd_ptr_q <= '0;
            dq_wr_ptr_q <= '0;
            dq_rd_ptr_q <= '0;
            rq_cnt_q    <= '0;
            dq_cnt_q    <= '0;
            rel_req_q   <= 1'b0;
            rel_addr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rq_wr_ptr_q <= rq_wr_ptr_d;
            rq_rd_ptr_q <= rq_rd_ptr_d;
            dq_wr_ptr_q <= dq_wr_ptr_d;
            dq_rd_ptr_q <= dq_rd_ptr_d;
            rq_cnt_q    <= rq_cnt_d;
            dq_cnt_q    <= dq_cnt_d;
            rel_req_q   <= rel_req_d;
            rel_addr_q  <= rel_addr_d;
            err_q       <= err_d;
        end
    end

    // Address storage needs no reset: occupancy is governed by the counters.
    always_ff @(posedge clk_i) begin
        if (rq_push) rq_mem_q[rq_wr_ptr_q] <= ac_addr_i;
        if (dq_push) dq_mem_q[dq_wr_ptr_q] <= rq_head;
    end

    assign cm_x_req_o  = rel_req_q;
    assign cm_x_addr_o = rel_addr_q;
    assign err_o       = err_q;

    cr_without_snoop_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cr_hs && !rq_nonempty))
        else $warning("release unit protocol error: CR handshake with no outstanding snoop");

    cd_last_without_data_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cd_last_hs && !dq_nonempty))
        else $warning("release unit protocol error: CD last with no snoop awaiting data");

endmodule

// File: tb/tb_ace_ccu_cm_release_unit.sv
module tb_ace_ccu_cm_release_unit;

    localparam int AW  = 40;
    localparam int MAX = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          ac_valid_i = 1'b0, ac_ready_i = 1'b0;
    logic [AW-1:0] ac_addr_i = '0;
    logic          cr_valid_i = 1'b0, cr_ready_i = 1'b0, cr_data_transfer_i = 1'b0;
    logic          cd_valid_i = 1'b0, cd_ready_i = 1'b0, cd_last_i = 1'b0;
    logic          ac_ready_o, ac_valid_o, cr_ready_o, cr_valid_o, cd_ready_o, cd_valid_o;
    logic          cm_x_req_o, err_o;
    logic [AW-1:0] cm_x_addr_o;

    ace_ccu_cm_release_unit #(.CmAddrWidth(AW), .MaxSnoopTrans(MAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o),
        .cr_data_transfer_i(cr_data_transfer_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_last_i(cd_last_i),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i),
        .cm_x_req_o(cm_x_req_o), .cm_x_addr_o(cm_x_addr_o), .err_o(err_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Snoops are kept as plain address lists; a release is whatever address
    // completed on the last edge.
    logic [AW-1:0] rq_m[$];
    logic [AW-1:0] dq_m[$];
    logic          exp_req_m;
    logic [AW-1:0] exp_addr_m;
    logic          err_m;

    task automatic model_reset();
        rq_m.delete();
        dq_m.delete();
        exp_req_m  = 1'b0;
        exp_addr_m = '0;
        err_m      = 1'b0;
    endtask

    function automatic bit model_full();
        return (rq_m.size() + dq_m.size()) >= MAX;
    endfunction

    task automatic model_check();
        bit   full;
        bit   blk;
        logic [5:0] exp_comb;
        full = model_full();
        blk  = cd_valid_i && cd_ready_i && cd_last_i && !cr_data_transfer_i;
        exp_comb = {ac_valid_i && !full, ac_ready_i && !full,
                    cr_valid_i && !blk, cr_ready_i && !blk,
                    cd_valid_i, cd_ready_i};
        chk("model_handshake_wires",
            64'({ac_valid_o, ac_ready_o, cr_valid_o, cr_ready_o, cd_valid_o, cd_ready_o}),
            64'(exp_comb));
        chk("model_req", 64'(cm_x_req_o), 64'(exp_req_m));
        chk("model_addr", 64'(cm_x_addr_o), 64'(exp_addr_m));
        chk("model_err", 64'(err_o), 64'(err_m));
    endtask

    task automatic model_advance();
        bit full, blk, ac_hs, cr_hs, cd_last_hs, rel;
        logic [AW-1:0] rel_addr, h;
        full       = model_full();
        blk        = cd_valid_i && cd_ready_i && cd_last_i && !cr_data_transfer_i;
        ac_hs      = ac_valid_i && ac_ready_i && !full;
        cr_hs      = cr_valid_i && cr_ready_i && !blk;
        cd_last_hs = cd_valid_i && cd_ready_i && cd_last_i;
        rel        = 1'b0;
        rel_addr   = '0;
        if (cd_last_hs) begin
            if (dq_m.size() == 0) err_m = 1'b1;
            else begin
                rel      = 1'b1;
                rel_addr = dq_m.pop_front();
            end
        end
        if (cr_hs) begin
            if (rq_m.size() == 0) err_m = 1'b1;
            else begin
                h = rq_m.pop_front();
                if (cr_data_transfer_i) dq_m.push_back(h);
                else begin
                    rel      = 1'b1;
                    rel_addr = h;
                end
            end
        end
        if (ac_hs) rq_m.push_back(ac_addr_i);
        exp_req_m = rel;
        if (rel) exp_addr_m = rel_addr;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic acv, input logic acr, input logic [AW-1:0] addr,
                         input logic crv, input logic crr, input logic dt,
                         input logic cdv, input logic cdr, input logic last);
        ac_valid_i = acv; ac_ready_i = acr; ac_addr_i = addr;
        cr_valid_i = crv; cr_ready_i = crr; cr_data_transfer_i = dt;
        cd_valid_i = cdv; cd_ready_i = cdr; cd_last_i = last;
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the
    // falling edge, then the model takes the rising edge.
    task automatic step();
        @(negedge clk_i);
        model_check();
        model_advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        #2;
        model_reset();
        @(negedge clk_i);
        model_check();
        chk("rst_req", 64'(cm_x_req_o), 64'(0));
        chk("rst_addr", 64'(cm_x_addr_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          acv, acr;
        logic [AW-1:0] addr;
        logic          crv, crr, dt, cdv, cdr, last;
        logic          e_acv, e_acr, e_crv, e_crr, e_req;
        logic [AW-1:0] e_addr;
        logic          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic acv, input logic acr, input logic [AW-1:0] addr,
                                input logic crv, input logic crr, input logic dt,
                                input logic cdv, input logic cdr, input logic last,
                                input logic e_acv, input logic e_acr, input logic e_crv,
                                input logic e_crr, input logic e_req,
                                input logic [AW-1:0] e_addr, input logic e_err);
        vec_t v;
        v.acv = acv; v.acr = acr; v.addr = addr;
        v.crv = crv; v.crr = crr; v.dt = dt;
        v.cdv = cdv; v.cdr = cdr; v.last = last;
        v.e_acv = e_acv; v.e_acr = e_acr; v.e_crv = e_crv; v.e_crr = e_crr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [AW-1:0] ra;

        // Registered outputs in each row reflect the previous row's edge.
        // single CR DT=0 release
        tbl.push_back(mk(1,1,'h100, 0,0,0, 0,0,0,  1,1,0,0, 0,'h000, 0));
        tbl.push_back(mk(0,0,'h000, 1,1,0, 0,0,0,  0,0,1,1, 0,'h000, 0));
        tbl.push_back(mk(0,0,'h000, 0,0,0, 0,0,0,  0,0,0,0, 1,'h100, 0));
        // CR DT=1 then four CD beats
        tbl.push_back(mk(1,1,'h200, 0,0,0, 0,0,0,  1,1,0,0, 0,'h100, 0));
        tbl.push_back(mk(0,0,'h000, 1,1,1, 0,0,0,  0,0,1,1, 0,'h100, 0));
        tbl.push_back(mk(0,0,'h000, 0,0,0, 1,1,0,  0,0,0,0, 0,'h100, 0));
        tbl.push_back(mk(0,0,'h000, 0,0,0, 1,1,0,  0,0,0,0, 0,'h100, 0));
        tbl.push_back(mk(0,0,'h000, 0,0,0, 1,1,0,  0,0,0,0, 0,'h100, 0));
        tbl.push_back(mk(0,0,'h000, 0,0,0, 1,1,1,  0,0,0,0, 0,'h100, 0));
        tbl.push_back(mk(0,0,'h000, 0,0,0, 0,0,0,  0,0,0,0, 1,'h200, 0));
        // fill to MaxSnoopTrans, fifth waits for the first release
        tbl.push_back(mk(1,1,'h0A0, 0,0,0, 0,0,0,  1,1,0,0, 0,'h200, 0));
        tbl.push_back(mk(1,1,'h0B0, 0,0,0, 0,0,0,  1,1,0,0, 0,'h200, 0));
        tbl.push_back(mk(1,1,'h0C0, 0,0,0, 0,0,0,  1,1,0,0, 0,'h200, 0));
        tbl.push_back(mk(1,1,'h0D0, 0,0,0, 0,0,0,  1,1,0,0, 0,'h200, 0));
        tbl.push_back(mk(1,1,'h0E0, 0,0,0, 0,0,0,  0,0,0,0, 0,'h200, 0));
        tbl.push_back(mk(1,1,'h0E0, 1,1,0, 0,0,0,  0,0,1,1, 0,'h200, 0));
        tbl.push_back(mk(1,1,'h0E0, 0,0,0, 0,0,0,  1,1,0,0, 1,'h0A0, 0));
        // drain B0..E0
        tbl.push_back(mk(0,0,'h000, 1,1,0, 0,0,0,  0,0,1,1, 0,'h0A0, 0));
        tbl.push_back(mk(0,0,'h000, 1,1,0, 0,0,0,  0,0,1,1, 1,'h0B0, 0));
        tbl.push_back(mk(0,0,'h000, 1,1,0, 0,0,0,  0,0,1,1, 1,'h0C0, 0));
        tbl.push_back(mk(0,0,'h000, 1,1,0, 0,0,0,  0,0,1,1, 1,'h0D0, 0));
        // CD last for 0x300 collides with CR DT=0 for 0x400
        tbl.push_back(mk(1,1,'h300, 0,0,0, 0,0,0,  1,1,0,0, 1,'h0E0, 0));
        tbl.push_back(mk(1,1,'h400, 1,1,1, 0,0,0,  1,1,1,1, 0,'h0E0, 0));
        tbl.push_back(mk(0,0,'h000, 1,1,0, 1,1,1,  0,0,0,0, 0,'h0E0, 0));
        tbl.push_back(mk(0,0,'h000, 1,1,0, 0,0,0,  0,0,1,1, 1,'h300, 0));
        tbl.push_back(mk(0,0,'h000, 0,0,0, 0,0,0,  0,0,0,0, 1,'h400, 0));
        tbl.push_back(mk(0,0,'h000, 0,0,0, 0,0,0,  0,0,0,0, 0,'h400, 0));

        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.acv, v.acr, v.addr, v.crv, v.crr, v.dt, v.cdv, v.cdr, v.last);
            @(negedge clk_i);
            chk($sformatf("vec%0d_ac", i), 64'({ac_valid_o, ac_ready_o}), 64'({v.e_acv, v.e_acr}));
            chk($sformatf("vec%0d_cr", i), 64'({cr_valid_o, cr_ready_o}), 64'({v.e_crv, v.e_crr}));
            chk($sformatf("vec%0d_req", i), 64'(cm_x_req_o), 64'(v.e_req));
            chk($sformatf("vec%0d_addr", i), 64'(cm_x_addr_o), 64'(v.e_addr));
            chk($sformatf("vec%0d_err", i), 64'(err_o), 64'(v.e_err));
            model_check();
            model_advance();
            @(posedge clk_i);
            #1;
        end

        // CR with nothing outstanding: error, no release
        drive(0,0,'0, 1,1,0, 0,0,0);
        step();
        idle();
        chk("t5_err_set", 64'(err_o), 64'(1));
        chk("t5_no_req", 64'(cm_x_req_o), 64'(0));
        step();
        chk("t5_err_sticky", 64'(err_o), 64'(1));

        // reset in the middle of a burst drops everything silently
        drive(1,1,'h500, 0,0,0, 0,0,0);
        step();
        drive(1,1,'h600, 1,1,1, 0,0,0);
        step();
        drive(0,0,'0, 0,0,0, 1,1,0);
        step();
        do_reset();
        chk("t5_post_rst_err", 64'(err_o), 64'(0));
        chk("t5_post_rst_addr", 64'(cm_x_addr_o), 64'(0));
        // a CD last now has nothing to complete
        drive(0,0,'0, 0,0,0, 1,1,1);
        step();
        idle();
        chk("t5_dq_empty_err", 64'(err_o), 64'(1));
        chk("t5_dq_empty_no_req", 64'(cm_x_req_o), 64'(0));
        step();
        // full capacity is available again: four accepted, fifth held
        for (int i = 0; i < MAX; i++) begin
            drive(1,1,AW'(32'h700 + 32'(i)), 0,0,0, 0,0,0);
            step();
        end
        drive(1,1,'h7FF, 0,0,0, 0,0,0);
        #1;
        chk("t5_full_ac_valid", 64'(ac_valid_o), 64'(0));
        chk("t5_full_ac_ready", 64'(ac_ready_o), 64'(0));
        step();
        do_reset();

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            if (c % 500 == 499) begin
                do_reset();
            end else begin
                ra = AW'({$urandom(), $urandom()});
                ac_valid_i = ($urandom_range(0, 2) != 0);
                ac_ready_i = ($urandom_range(0, 3) != 0);
                ac_addr_i  = ra;
                cr_valid_i = ($urandom_range(0, 1) == 1) &&
                             (rq_m.size() > 0 || $urandom_range(0, 99) == 0);
                cr_ready_i = ($urandom_range(0, 3) != 0);
                cr_data_transfer_i = $urandom_range(0, 1) == 1;
                cd_valid_i = ($urandom_range(0, 1) == 1);
                cd_ready_i = ($urandom_range(0, 3) != 0);
                cd_last_i  = ($urandom_range(0, 2) == 0) &&
                             (dq_m.size() > 0 || $urandom_range(0, 99) == 0);
                step();
            end
        end

        idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
